// File: rtl/alu_pkg.sv
// Shared op codes, op type and controller state encoding for the pipelined ALU.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t OP_ZERO  = 5'd0;
  localparam alu_op_t OP_ONE   = 5'd1;
  localparam alu_op_t OP_ONES  = 5'd2;
  localparam alu_op_t OP_128   = 5'd3;
  localparam alu_op_t OP_A     = 5'd4;
  localparam alu_op_t OP_B     = 5'd5;
  localparam alu_op_t OP_NEG_A = 5'd6;
  localparam alu_op_t OP_NEG_B = 5'd7;
  localparam alu_op_t OP_NOT_A = 5'd8;
  localparam alu_op_t OP_NOT_B = 5'd9;
  localparam alu_op_t OP_ADD   = 5'd10;
  localparam alu_op_t OP_SUB   = 5'd11;
  localparam alu_op_t OP_MUL   = 5'd12;
  localparam alu_op_t OP_INC_A = 5'd13;
  localparam alu_op_t OP_DEC_A = 5'd14;
  localparam alu_op_t OP_INC_B = 5'd15;
  localparam alu_op_t OP_DEC_B = 5'd16;
  localparam alu_op_t OP_AND   = 5'd17;
  localparam alu_op_t OP_OR    = 5'd18;
  localparam alu_op_t OP_XOR   = 5'd19;
  localparam alu_op_t OP_SHL   = 5'd20;
  localparam alu_op_t OP_SHR   = 5'd21;
  localparam alu_op_t OP_LT    = 5'd22;
  localparam alu_op_t OP_GT    = 5'd23;

  typedef enum logic {IDLE, MUL} alu_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  alu_op_t          ctrl;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_bus;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             n;
  logic             o;

  modport master (
    output in_valid, ctrl, acc, b_bus,
    input  busy, out_valid, out, z, n, o
  );

  modport slave (
    input  in_valid, ctrl, acc, b_bus,
    output busy, out_valid, out, z, n, o
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk_100,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] psum;
  logic [2*WIDTH-1:0] partial;
  logic [SHW-1:0]     count;
  logic               run;

  // product is the sum including this cycle's step, so the caller can
  // register the final value on the same edge as the last iteration.
  always_comb begin
    partial = mplier[count] ? (mcand << count) : '0;
    product = psum + partial;
    done    = run && (count == SHW'(WIDTH - 1));
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      psum   <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      psum   <= '0;
      count  <= '0;
      run    <= 1'b1;
    end else if (run) begin
      psum  <= product;
      count <= count + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/busy handshake; multiply is handed to alu_mul_seq.
//   state | meaning
//   IDLE  | accepting requests, single-cycle ops complete on the accept edge
//   MUL   | multiply iterating, busy=1, requests dropped
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk_100,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);

  localparam int               MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  alu_state_t state, state_nxt;

  logic [WIDTH-1:0]   a, b, res;
  logic               ovf;
  logic               sh_big;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               load, load_o;
  logic [WIDTH-1:0]   load_val;

  assign a      = bus.acc;
  assign b      = bus.b_bus;
  assign sh_big = (b >= W_LIM);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.ctrl)
      OP_ZERO:  res = '0;
      OP_ONE:   res = WIDTH'(1);
      OP_ONES:  res = '1;
      OP_128:   res = WIDTH'(128);
      OP_A:     res = a;
      OP_B:     res = b;
      OP_NEG_A: begin res = -a; ovf = a[MSB] & res[MSB]; end
      OP_NEG_B: begin res = -b; ovf = b[MSB] & res[MSB]; end
      OP_NOT_A: res = ~a;
      OP_NOT_B: res = ~b;
      OP_ADD: begin
        res = a + b;
        ovf = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res = a - b;
        ovf = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_INC_A: begin res = a + WIDTH'(1); ovf = ~a[MSB] &  res[MSB]; end
      OP_DEC_A: begin res = a - WIDTH'(1); ovf =  a[MSB] & ~res[MSB]; end
      OP_INC_B: begin res = b + WIDTH'(1); ovf = ~b[MSB] &  res[MSB]; end
      OP_DEC_B: begin res = b - WIDTH'(1); ovf =  b[MSB] & ~res[MSB]; end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      // large shift amounts must not alias onto the low SHW bits
      OP_SHL:   res = sh_big ? '0 : (a << b[SHW-1:0]);
      OP_SHR:   res = sh_big ? '0 : (a >> b[SHW-1:0]);
      OP_LT:    res = (a < b) ? WIDTH'(1) : '0;
      OP_GT:    res = (a > b) ? WIDTH'(1) : '0;
      default:  res = '0;
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk_100) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    load_o    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.ctrl == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end else begin
            load     = 1'b1;
            load_val = res;
            load_o   = ovf;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          load      = 1'b1;
          load_val  = mul_prod[WIDTH-1:0];
          load_o    = |mul_prod[2*WIDTH-1:WIDTH];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == MUL);

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.z         <= 1'b0;
      bus.n         <= 1'b0;
      bus.o         <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= load;
      if (load) begin
        bus.out <= load_val;
        bus.z   <= (load_val == '0);
        bus.n   <= load_val[MSB];
        bus.o   <= load_o;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16: single-cycle op table plus multiply/reset sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk_100 = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_100 = ~clk_100;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         o;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic z, input logic n, input logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.n = n; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.in_valid = v;
    bus.ctrl     = op;
    bus.acc      = a;
    bus.b_bus    = b;
  endtask

  task automatic chk_result(input string name, input logic [W-1:0] r, input logic z,
                            input logic n, input logic o);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".out"},   32'(bus.out),       32'(r));
    chk({name, ".z"},     32'(bus.z),         32'(z));
    chk({name, ".n"},     32'(bus.n),         32'(n));
    chk({name, ".o"},     32'(bus.o),         32'(o));
    chk({name, ".busy"},  32'(bus.busy),      32'd0);
  endtask

  // Accept at edge k, watch edges k+1..k+15 (busy, no result, out held),
  // then expect the product at edge k+16. Optionally try a request mid-way.
  task automatic mul_run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic z, input logic n, input logic o,
                         input logic try_drop);
    logic [W-1:0] held;
    held = bus.out;
    drive(1'b1, OP_MUL, a, b);
    tick();
    drive(1'b0, OP_ZERO, '0, '0);
    chk({name, ".busy0"}, 32'(bus.busy), 32'd1);
    chk({name, ".nov0"},  32'(bus.out_valid), 32'd0);
    for (int i = 1; i <= W - 1; i++) begin
      tick();
      chk($sformatf("%s.busy%0d", name, i), 32'(bus.busy), 32'd1);
      chk($sformatf("%s.nov%0d", name, i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("%s.hold%0d", name, i), 32'(bus.out), 32'(held));
      if (try_drop && i == 4) drive(1'b1, OP_A, 16'hAAAA, 16'h0000);
      if (i == 5)             drive(1'b0, OP_ZERO, '0, '0);
    end
    tick();
    chk_result(name, r, z, n, o);
  endtask

  initial begin
    add(OP_ZERO,  16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(OP_ONE,   16'h0000, 16'h0000, 16'h0001, 0, 0, 0);
    add(OP_ONES,  16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0);
    add(OP_128,   16'h0000, 16'h0000, 16'h0080, 0, 0, 0);
    add(OP_A,     16'h1234, 16'h0007, 16'h1234, 0, 0, 0);
    add(OP_B,     16'h1234, 16'h0007, 16'h0007, 0, 0, 0);
    add(OP_NEG_A, 16'h8000, 16'h0000, 16'h8000, 0, 1, 1);
    add(OP_NEG_A, 16'h0001, 16'h0000, 16'hFFFF, 0, 1, 0);
    add(OP_NEG_B, 16'h0000, 16'h0005, 16'hFFFB, 0, 1, 0);
    add(OP_NEG_B, 16'h0000, 16'h8000, 16'h8000, 0, 1, 1);
    add(OP_NOT_A, 16'h00FF, 16'h0000, 16'hFF00, 0, 1, 0);
    add(OP_NOT_B, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(OP_ADD,   16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1);
    add(OP_ADD,   16'h8000, 16'h8000, 16'h0000, 1, 0, 1);
    add(OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1);
    add(OP_SUB,   16'h0005, 16'h0007, 16'hFFFE, 0, 1, 0);
    add(OP_INC_A, 16'h7FFF, 16'h0000, 16'h8000, 0, 1, 1);
    add(OP_DEC_A, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 1);
    add(OP_INC_B, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(OP_DEC_B, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0);
    add(OP_DEC_B, 16'h0000, 16'h8000, 16'h7FFF, 0, 0, 1);
    add(OP_AND,   16'hF0F0, 16'hFF00, 16'hF000, 0, 1, 0);
    add(OP_OR,    16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 1, 0);
    add(OP_XOR,   16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(OP_SHL,   16'h000C, 16'h0002, 16'h0030, 0, 0, 0);
    add(OP_SHL,   16'h000C, 16'h0014, 16'h0000, 1, 0, 0);
    add(OP_SHL,   16'h0001, 16'h000F, 16'h8000, 0, 1, 0);
    add(OP_SHL,   16'h0001, 16'h0010, 16'h0000, 1, 0, 0);
    add(OP_SHR,   16'h000C, 16'h0002, 16'h0003, 0, 0, 0);
    add(OP_SHR,   16'h8000, 16'h000F, 16'h0001, 0, 0, 0);
    add(OP_SHR,   16'hFFFF, 16'h0011, 16'h0000, 1, 0, 0);
    add(OP_LT,    16'h0002, 16'h000C, 16'h0001, 0, 0, 0);
    add(OP_LT,    16'h8000, 16'h0001, 16'h0000, 1, 0, 0);
    add(OP_GT,    16'h0002, 16'h000C, 16'h0000, 1, 0, 0);
    add(OP_GT,    16'h8000, 16'h0001, 16'h0001, 0, 0, 0);
    add(5'd24,    16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);
    add(5'd31,    16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);

    // Reset held for two edges with a live request on the bus.
    drive(1'b1, OP_ADD, 16'h0001, 16'h0001);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst.out",   32'(bus.out),       32'd0);
    chk("rst.z",     32'(bus.z),         32'd0);
    chk("rst.n",     32'(bus.n),         32'd0);
    chk("rst.o",     32'(bus.o),         32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.busy",  32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    tick();
    chk_result("rel", 16'h0002, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk_result($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].o);
    end
    drive(1'b0, OP_ONE, '0, '0);
    tick();
    chk("idle.valid", 32'(bus.out_valid), 32'd0);
    chk("idle.hold",  32'(bus.out),       32'h0000);

    drive(1'b1, OP_ONE, '0, '0);
    tick();
    mul_run("mul180", 16'd12, 16'd15, 16'd180, 0, 0, 0, 1'b1);
    drive(1'b1, OP_B, 16'h0000, 16'h0009);
    tick();
    chk_result("after_mul", 16'h0009, 0, 0, 0);
    drive(1'b0, OP_ZERO, '0, '0);
    tick();
    chk("after_mul.drop", 32'(bus.out_valid), 32'd0);

    mul_run("mul_ovf",  16'h0100, 16'h0100, 16'h0000, 1, 0, 1, 1'b0);
    mul_run("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 1, 1'b0);
    mul_run("mul_noov", 16'h00FF, 16'h0101, 16'hFFFF, 0, 1, 0, 1'b0);

    // Reset in the middle of a multiply discards the partial product.
    drive(1'b1, OP_ONE, '0, '0);
    tick();
    drive(1'b1, OP_MUL, 16'd3, 16'd5);
    tick();
    drive(1'b0, OP_ZERO, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("mrst.busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst.busy",  32'(bus.busy),      32'd0);
    chk("mrst.out",   32'(bus.out),       32'd0);
    chk("mrst.valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("mrst.ghost%0d", i), 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, OP_B, 16'h0000, 16'h0007);
    tick();
    chk_result("mrst.fresh", 16'h0007, 0, 0, 0);
    drive(1'b0, OP_ZERO, '0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
